// File: rtl/ysyx_22040895_mdu.sv
// Multi-cycle multiply/divide unit: radix-2 shift-add for mul/mulw, signed restoring division for divw/remw.
// State | meaning: IDLE accept request; CALC iterate one bit per cycle; DONE hold result until consumed.
module ysyx_22040895_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mduop_i_mdu,
  input  logic [XLEN-1:0] src1_i_mdu,
  input  logic [XLEN-1:0] src2_i_mdu,
  input  logic            valid_i_mdu,
  output logic            ready_o_mdu,
  input  logic            flush_i_mdu,
  output logic [XLEN-1:0] result_o_mdu,
  output logic            out_valid_o_mdu,
  input  logic            out_ready_i_mdu,
  output logic            busy_o_mdu
);

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_MULW = 4'b0101;
  localparam logic [3:0] OP_DIVW = 4'b1001;
  localparam logic [3:0] OP_REMW = 4'b1101;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [5:0]      r_cnt;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_res;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_is_mulw;
  logic            w_is_div;
  logic            w_known;
  logic [31:0]     w_s1;
  logic [31:0]     w_s2;
  logic [31:0]     w_s1_mag;
  logic [31:0]     w_s2_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_direct;
  logic [XLEN-1:0] w_direct_res;

  logic [32:0]     w_rem_sh;
  logic [32:0]     w_dvs;
  logic            w_ge;
  logic [32:0]     w_diff;
  logic [32:0]     w_rem_new;
  logic [31:0]     w_q_new;
  logic [31:0]     w_q_signed;
  logic [31:0]     w_rem_signed;
  logic [XLEN-1:0] w_acc_it;
  logic [XLEN-1:0] w_a_it;
  logic [XLEN-1:0] w_b_it;
  logic [XLEN-1:0] w_final;

  assign ready_o_mdu     = (r_state == IDLE) && !flush_i_mdu;
  assign busy_o_mdu      = (r_state != IDLE);
  assign out_valid_o_mdu = (r_state == DONE);
  assign result_o_mdu    = out_valid_o_mdu ? r_res : '0;

  assign w_accept   = valid_i_mdu && ready_o_mdu && (mduop_i_mdu != 4'b0000);
  assign w_is_mul   = (mduop_i_mdu == OP_MUL);
  assign w_is_mulw  = (mduop_i_mdu == OP_MULW);
  assign w_is_div   = (mduop_i_mdu == OP_DIVW) || (mduop_i_mdu == OP_REMW);
  assign w_known    = w_is_mul || w_is_mulw || w_is_div;
  assign w_s1       = src1_i_mdu[31:0];
  assign w_s2       = src2_i_mdu[31:0];
  assign w_s1_mag   = w_s1[31] ? (~w_s1 + 32'd1) : w_s1;
  assign w_s2_mag   = w_s2[31] ? (~w_s2 + 32'd1) : w_s2;
  assign w_div_zero = (w_s2 == 32'd0);
  assign w_div_ovf  = (w_s1 == 32'h8000_0000) && (w_s2 == 32'hFFFF_FFFF);
  assign w_direct   = !w_known || (w_is_div && (w_div_zero || w_div_ovf));

  always_comb begin
    w_direct_res = '0;
    if (w_is_div && w_div_zero)
      w_direct_res = (mduop_i_mdu == OP_DIVW) ? '1 : {{32{w_s1[31]}}, w_s1};
    else if (w_is_div && w_div_ovf)
      w_direct_res = (mduop_i_mdu == OP_DIVW) ? 64'hFFFF_FFFF_8000_0000 : '0;
  end

  // Division: r_a shifts dividend bits out of the top while quotient bits enter at the bottom; r_acc holds the remainder.
  assign w_rem_sh     = {r_acc[31:0], r_a[31]};
  assign w_dvs        = {1'b0, r_b[31:0]};
  assign w_ge         = (w_rem_sh >= w_dvs);
  assign w_diff       = w_rem_sh - w_dvs;
  assign w_rem_new    = w_ge ? w_diff : w_rem_sh;
  assign w_q_new      = {r_a[30:0], w_ge};
  assign w_q_signed   = r_neg_q ? (32'd0 - w_q_new) : w_q_new;
  assign w_rem_signed = r_neg_r ? (32'd0 - w_rem_new[31:0]) : w_rem_new[31:0];

  always_comb begin
    if (r_op[3]) begin
      w_acc_it = {31'd0, w_rem_new};
      w_a_it   = {32'd0, w_q_new};
      w_b_it   = r_b;
    end else begin
      w_acc_it = r_acc + (r_b[0] ? r_a : '0);
      w_a_it   = r_a << 1;
      w_b_it   = r_b >> 1;
    end
  end

  always_comb begin
    case (r_op)
      OP_MUL:  w_final = w_acc_it;
      OP_MULW: w_final = {{32{w_acc_it[31]}}, w_acc_it[31:0]};
      OP_DIVW: w_final = {{32{w_q_signed[31]}}, w_q_signed};
      default: w_final = {{32{w_rem_signed[31]}}, w_rem_signed};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_direct ? DONE : CALC;
      CALC: begin
        if (flush_i_mdu)        w_state_nxt = IDLE;
        else if (r_cnt == 6'd0) w_state_nxt = DONE;
      end
      DONE: if (flush_i_mdu || out_ready_i_mdu) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (flush_i_mdu) begin
      r_res <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_op    <= mduop_i_mdu;
        r_cnt   <= w_is_mul ? 6'd63 : 6'd31;
        r_acc   <= '0;
        r_res   <= w_direct_res;
        r_neg_q <= w_s1[31] ^ w_s2[31];
        r_neg_r <= w_s1[31];
        if (w_is_mul) begin
          r_a <= src1_i_mdu;
          r_b <= src2_i_mdu;
        end else if (w_is_mulw) begin
          r_a <= {32'd0, w_s1};
          r_b <= {32'd0, w_s2};
        end else begin
          r_a <= {32'd0, w_s1_mag};
          r_b <= {32'd0, w_s2_mag};
        end
      end
    end else if (r_state == CALC) begin
      r_acc <= w_acc_it;
      r_a   <= w_a_it;
      r_b   <= w_b_it;
      if (r_cnt == 6'd0) r_res <= w_final;
      else               r_cnt <= r_cnt - 6'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Self-checking bench for ysyx_22040895_mdu: vector table plus handwritten flush/reset/backpressure sequences.
module tb_ysyx_22040895_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mduop;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        valid;
  logic        flush;
  logic        out_ready;
  logic        ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] result;

  localparam logic [3:0] MUL  = 4'b0001;
  localparam logic [3:0] MULW = 4'b0101;
  localparam logic [3:0] DIVW = 4'b1001;
  localparam logic [3:0] REMW = 4'b1101;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          lat;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  ysyx_22040895_mdu #(.XLEN(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .mduop_i_mdu     (mduop),
    .src1_i_mdu      (src1),
    .src2_i_mdu      (src2),
    .valid_i_mdu     (valid),
    .ready_o_mdu     (ready),
    .flush_i_mdu     (flush),
    .result_o_mdu    (result),
    .out_valid_o_mdu (out_valid),
    .out_ready_i_mdu (out_ready),
    .busy_o_mdu      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drives one request, expects it accepted at the next edge, then scrambles the operand inputs.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    sb_t e;
    @(negedge clk);
    chk("ready_before_req", {63'd0, ready}, 64'd1);
    mduop = op;
    src1  = a;
    src2  = b;
    valid = 1'b1;
    e.exp = exp;
    e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    src1  = {$urandom, $urandom};
    src2  = {$urandom, $urandom};
  endtask

  task automatic collect(input string name);
    int  edges;
    sb_t e;
    edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({name, "_out_valid"}, {63'd0, out_valid}, 64'd1);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_latency"}, 64'(edges), 64'(e.lat));
      chk({name, "_result"}, result, e.exp);
    end
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({name, "_exit_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, "_exit_result"}, result, 64'd0);
      chk({name, "_exit_ready"}, {63'd0, ready}, 64'd1);
    end
  endtask

  initial begin
    vec_t vecs[16];
    int          bad;
    logic [63:0] held;

    vecs[0]  = '{MUL,  64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[1]  = '{MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[2]  = '{MULW, 64'hFFFF_FFFF_0000_0003, 64'd5, 64'h0000_0000_0000_000F, 33};
    vecs[3]  = '{DIVW, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[4]  = '{REMW, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[5]  = '{DIVW, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{REMW, 64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[8]  = '{REMW, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{4'b0011, 64'd7, 64'd9, 64'd0, 1};
    vecs[10] = '{MUL,  64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00, 65};
    vecs[11] = '{DIVW, 64'd100, 64'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 33};
    vecs[12] = '{REMW, 64'd100, 64'hFFFF_FFF9, 64'd2, 33};
    vecs[13] = '{REMW, 64'hABCD_0000_0000_000D, 64'hFFFF_FFFB, 64'd3, 33};
    vecs[14] = '{MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65};
    vecs[15] = '{MULW, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33};

    rst = 1'b0; mduop = '0; src1 = '0; src2 = '0;
    valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      collect($sformatf("vec%0d", i));
    end

    // opcode 0000 is never accepted
    @(negedge clk);
    mduop = 4'b0000; valid = 1'b1;
    @(posedge clk);
    #1;
    chk("op0_busy", {63'd0, busy}, 64'd0);
    chk("op0_ready", {63'd0, ready}, 64'd1);
    valid = 1'b0;

    // backpressure
    out_ready = 1'b0;
    issue(MULW, 64'd3, 64'd4, 64'd12, 33);
    collect("bp");
    held = result;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || result !== held || ready || !busy) bad++;
    end
    chk("bp_hold_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_busy", {63'd0, busy}, 64'd0);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);

    // flush at CALC cycle 10 of mul
    @(negedge clk);
    mduop = MUL; src1 = 64'd6; src2 = 64'd7; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush_pre_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    chk("flush_ready_low", {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("flush_calc_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad++;
    end
    chk("flush_no_result", 64'(bad), 64'd0);

    // flush with valid high in IDLE: no accept
    @(negedge clk);
    flush = 1'b1; valid = 1'b1; mduop = MUL;
    @(posedge clk);
    #1;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    issue(MULW, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd1, 33);
    collect("after_flush");

    // reset mid-CALC, then accept on first edge after release
    @(negedge clk);
    mduop = MUL; src1 = 64'd2; src2 = 64'd2; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_calc_busy", {63'd0, busy}, 64'd0);
    chk("rst_calc_ready", {63'd0, ready}, 64'd1);
    chk("rst_calc_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    issue(DIVW, 64'd9, 64'd3, 64'd3, 33);
    collect("post_rst");

    // reset in DONE discards pending result
    out_ready = 1'b0;
    @(negedge clk);
    mduop = DIVW; src1 = 64'd5; src2 = 64'd0; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    chk("rst_done_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_done_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_done_result", result, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad++;
    end
    chk("rst_done_idle", 64'(bad), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
